// File: rtl/if_id_fetch_stage.sv
// Fetch stage of the 5-stage MIPS pipeline: program counter, IF/ID register,
// a stage FSM (RUN/HOLD/BUBBLE) and stall-monitoring counters.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STALL = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Stall,
  input  logic             FlushIF,
  input  logic             PCSrc,
  input  logic [31:0]      BranchTarget,
  input  logic [31:0]      Instruction_IF,
  output logic [31:0]      PC_IF,
  output logic [31:0]      Instruction_ID,
  output logic [31:0]      PCPlus4_ID,
  output logic             Valid_ID,
  output logic [4:0]       RS_ID,
  output logic [4:0]       RT_ID,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] StallCount,
  output logic             StallTimeout
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StHold   = 2'd1,
    StBubble = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [CNT_W-1:0] StallLim = CNT_W'(MAX_STALL);

  logic [31:0]      r_pc, r_instr, r_pc4;
  logic             r_valid;
  state_e           r_state;
  logic [CNT_W-1:0] r_stall_cnt, r_run_cnt;
  logic             r_timeout;

  logic [31:0]      w_pc_plus4, w_pc_next, w_instr_next, w_pc4_next;
  logic             w_valid_next;
  state_e           w_state_next;
  logic [CNT_W-1:0] w_stall_cnt_next, w_run_cnt_next;
  logic             w_timeout_next;

  always_comb begin
    w_pc_plus4 = r_pc + 32'd4;

    // Stall wins over a redirect; the branch re-asserts PCSrc once the stall clears.
    if (Stall) begin
      w_pc_next = r_pc;
    end else if (PCSrc) begin
      w_pc_next = BranchTarget;
    end else begin
      w_pc_next = w_pc_plus4;
    end

    w_instr_next = r_instr;
    w_pc4_next   = r_pc4;
    w_valid_next = r_valid;
    if (FlushIF || (!Stall && PCSrc)) begin
      w_instr_next = NOP_INSTR;
      w_pc4_next   = 32'd0;
      w_valid_next = 1'b0;
    end else if (!Stall) begin
      w_instr_next = Instruction_IF;
      w_pc4_next   = w_pc_plus4;
      w_valid_next = 1'b1;
    end

    w_state_next = StRun;
    if (Stall && !FlushIF) begin
      w_state_next = StHold;
    end else if (FlushIF || PCSrc) begin
      w_state_next = StBubble;
    end

    w_stall_cnt_next = r_stall_cnt;
    if (Stall && (r_stall_cnt != CntMax)) begin
      w_stall_cnt_next = r_stall_cnt + CntOne;
    end

    w_run_cnt_next = '0;
    if (Stall) begin
      w_run_cnt_next = (r_run_cnt != CntMax) ? (r_run_cnt + CntOne) : r_run_cnt;
    end

    w_timeout_next = r_timeout | (Stall && (w_run_cnt_next == StallLim));
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_pc        <= RESET_PC;
      r_instr     <= NOP_INSTR;
      r_pc4       <= 32'd0;
      r_valid     <= 1'b0;
      r_state     <= StRun;
      r_stall_cnt <= '0;
      r_run_cnt   <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_pc        <= w_pc_next;
      r_instr     <= w_instr_next;
      r_pc4       <= w_pc4_next;
      r_valid     <= w_valid_next;
      r_state     <= w_state_next;
      r_stall_cnt <= w_stall_cnt_next;
      r_run_cnt   <= w_run_cnt_next;
      r_timeout   <= w_timeout_next;
    end
  end

  assign PC_IF          = r_pc;
  assign Instruction_ID = r_instr;
  assign PCPlus4_ID     = r_pc4;
  assign Valid_ID       = r_valid;
  assign RS_ID          = r_instr[25:21];
  assign RT_ID          = r_instr[20:16];
  assign State          = r_state;
  assign StallCount     = r_stall_cnt;
  assign StallTimeout   = r_timeout;

endmodule
